bch15_7_decode_ctrl: RTL and testbench

Sequencing controller and decoder core for the BCH(15,7) t=2 code over GF(16), with primitive polynomial x^4+x+1.
- Accepts a received 15-bit word over a valid/ready handshake.
- Computes syndromes S1 and S3 serially by Horner evaluation.
- Solves the error-locator polynomial (Peterson, t=2), then runs a 15-step serial Chien search.
- Returns the corrected word with status over a second valid/ready handshake.
- Sits between the channel/deinterleaver front end and the message sink; one word in flight at a time.

---
 rtl/bch15_7_decode_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bch15_7_decode_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bch15_7_decode_ctrl.sv
// BCH(15,7) t=2 decoder over GF(16), x^4+x+1: serial syndromes,
// Peterson locator solve, serial Chien search, valid/ready on both sides.
module bch15_7_decode_ctrl #(
    parameter bit SKIP_CLEAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_cw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_cw,
    output logic [6:0]  out_msg,
    output logic [1:0]  err_count,
    output logic        uncorr,
    output logic [3:0]  syn_s1,
    output logic [3:0]  syn_s3
);

    typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, OUT} state_t;

    state_t      state, next;
    logic [3:0]  cnt;
    logic [14:0] raw, work;
    logic [3:0]  s1, s3, t1, t2;
    logic [1:0]  deg, roots;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;  4'h4: r = 4'hD;
            4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;  4'h8: r = 4'hF;
            4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;  4'hC: r = 4'hA;
            4'hD: r = 4'h4;  4'hE: r = 4'h3;  4'hF: r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    logic        bit_in, clean, s1z_bad, single, hit, chien_ok, last, skip_out;
    logic [3:0]  s1_cube, sig2_calc;
    logic [1:0]  roots_final;
    logic [14:0] work_flip;

    always_comb begin
        bit_in      = raw[4'd14 - cnt];
        last        = (cnt == 4'd14);
        s1_cube     = gf_mul(gf_mul(s1, s1), s1);
        sig2_calc   = gf_mul(s3, gf_inv(s1)) ^ gf_mul(s1, s1);
        clean       = (s1 == 4'h0) && (s3 == 4'h0);
        s1z_bad     = (s1 == 4'h0) && (s3 != 4'h0);
        single      = (s1 != 4'h0) && (s3 == s1_cube);
        skip_out    = s1z_bad || (SKIP_CLEAN && clean);
        hit         = ((4'h1 ^ t1 ^ t2) == 4'h0);
        roots_final = roots + {1'b0, hit};
        chien_ok    = (roots_final == deg);
        work_flip   = work ^ (hit ? (15'd1 << cnt) : 15'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (in_valid) next = SYND;
            SYND:    if (last) next = SOLVE;
            SOLVE:   next = skip_out ? OUT : CHIEN;
            CHIEN:   if (last) next = OUT;
            OUT:     if (out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    assign out_msg = out_cw[14:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            raw       <= 15'd0;
            work      <= 15'd0;
            s1        <= 4'h0;
            s3        <= 4'h0;
            t1        <= 4'h0;
            t2        <= 4'h0;
            deg       <= 2'd0;
            roots     <= 2'd0;
            out_cw    <= 15'd0;
            err_count <= 2'd0;
            uncorr    <= 1'b0;
            syn_s1    <= 4'h0;
            syn_s3    <= 4'h0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    raw  <= in_cw;
                    work <= in_cw;
                    s1   <= 4'h0;
                    s3   <= 4'h0;
                    cnt  <= 4'd0;
                end
                SYND: begin
                    s1  <= gf_mul(s1, 4'h2) ^ {3'b000, bit_in};
                    s3  <= gf_mul(s3, 4'h8) ^ {3'b000, bit_in};
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                end
                SOLVE: begin
                    t1    <= clean ? 4'h0 : s1;
                    t2    <= (clean || single) ? 4'h0 : sig2_calc;
                    deg   <= clean ? 2'd0 : (single ? 2'd1 : 2'd2);
                    roots <= 2'd0;
                    cnt   <= 4'd0;
                    if (skip_out) begin
                        out_cw    <= raw;
                        err_count <= 2'd0;
                        uncorr    <= s1z_bad;
                        syn_s1    <= s1;
                        syn_s3    <= s3;
                    end
                end
                CHIEN: begin
                    // terms step by alpha^-1 (0x9) and alpha^-2 (0xD)
                    work  <= work_flip;
                    roots <= roots_final;
                    t1    <= gf_mul(t1, 4'h9);
                    t2    <= gf_mul(t2, 4'hD);
                    cnt   <= last ? 4'd0 : cnt + 4'd1;
                    if (last) begin
                        out_cw    <= chien_ok ? work_flip : raw;
                        err_count <= chien_ok ? roots_final : 2'd0;
                        uncorr    <= !chien_ok;
                        syn_s1    <= s1;
                        syn_s3    <= s3;
                    end
                end
                OUT: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch15_7_decode_ctrl.sv
// Directed bench for bch15_7_decode_ctrl: vector table plus
// backpressure and mid-operation reset sequences.
module tb_bch15_7_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [14:0] in_cw = 15'd0;

    logic        in_ready_a, out_valid_a, uncorr_a;
    logic [14:0] out_cw_a;
    logic [6:0]  out_msg_a;
    logic [1:0]  err_count_a;
    logic [3:0]  syn_s1_a, syn_s3_a;

    logic        in_ready_b, out_valid_b, uncorr_b;
    logic [14:0] out_cw_b;
    logic [6:0]  out_msg_b;
    logic [1:0]  err_count_b;
    logic [3:0]  syn_s1_b, syn_s3_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bch15_7_decode_ctrl dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_cw(in_cw),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_cw(out_cw_a), .out_msg(out_msg_a), .err_count(err_count_a),
        .uncorr(uncorr_a), .syn_s1(syn_s1_a), .syn_s3(syn_s3_a)
    );

    bch15_7_decode_ctrl #(.SKIP_CLEAN(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_cw(in_cw),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_cw(out_cw_b), .out_msg(out_msg_b), .err_count(err_count_b),
        .uncorr(uncorr_b), .syn_s1(syn_s1_b), .syn_s3(syn_s3_b)
    );

    typedef struct {
        logic [14:0] cw;
        logic [14:0] exp_cw;
        logic [1:0]  ec;
        logic        unc;
        logic [3:0]  s1;
        logic [3:0]  s3;
        int          lat_a;
        int          lat_b;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [14:0] cw, input bit hold);
        in_cw = cw;
        in_valid = 1'b1;
        check("in_ready before accept", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        in_cw = ~cw;
    endtask

    task automatic wait_out(output int la, output int lb);
        bit busy_rdy;
        la = 0;
        lb = 0;
        busy_rdy = 1'b0;
        for (int n = 1; n <= 40 && (la == 0 || lb == 0); n++) begin
            @(posedge clk);
            #1;
            if (out_valid_a && la == 0) la = n;
            if (out_valid_b && lb == 0) lb = n;
            if (in_ready_a || in_ready_b) busy_rdy = 1'b1;
        end
        check("in_ready low while busy", {31'd0, busy_rdy}, 32'd0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_a after xfer", {31'd0, out_valid_a}, 32'd0);
        check("in_ready_a after xfer", {31'd0, in_ready_a}, 32'd1);
        check("out_valid_b after xfer", {31'd0, out_valid_b}, 32'd0);
        check("in_ready_b after xfer", {31'd0, in_ready_b}, 32'd1);
    endtask

    initial begin
        int la, lb;
        bit seen;

        vecs[0] = '{15'h01D1, 15'h01D1, 2'd0, 1'b0, 4'h0, 4'h0, 31, 16};
        vecs[1] = '{15'h01D9, 15'h01D1, 2'd1, 1'b0, 4'h8, 4'hA, 31, 31};
        vecs[2] = '{15'h41D0, 15'h01D1, 2'd2, 1'b0, 4'h8, 4'hE, 31, 31};
        vecs[3] = '{15'h0013, 15'h0013, 2'd0, 1'b1, 4'h0, 4'h6, 16, 16};
        vecs[4] = '{15'h05F1, 15'h01D1, 2'd2, 1'b0, 4'h1, 4'h0, 31, 31};
        vecs[5] = '{15'h008A, 15'h008A, 2'd0, 1'b1, 4'h1, 4'hE, 31, 31};
        vecs[6] = '{15'h41D1, 15'h01D1, 2'd1, 1'b0, 4'h9, 4'hF, 31, 31};
        vecs[7] = '{15'h01D0, 15'h01D1, 2'd1, 1'b0, 4'h1, 4'h1, 31, 31};

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready_a}, 32'd1);
        check("reset out_valid", {31'd0, out_valid_a}, 32'd0);
        check("reset out_cw", {17'd0, out_cw_a}, 32'd0);
        check("reset status", {21'd0, err_count_a, uncorr_a, syn_s1_a, syn_s3_a}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].cw, 1'b0);
            wait_out(la, lb);
            check($sformatf("v%0d lat_a", i), la, vecs[i].lat_a);
            check($sformatf("v%0d lat_b", i), lb, vecs[i].lat_b);
            check($sformatf("v%0d out_cw", i), {17'd0, out_cw_a}, {17'd0, vecs[i].exp_cw});
            check($sformatf("v%0d out_msg", i), {25'd0, out_msg_a}, {25'd0, vecs[i].exp_cw[14:8]});
            check($sformatf("v%0d err_count", i), {30'd0, err_count_a}, {30'd0, vecs[i].ec});
            check($sformatf("v%0d uncorr", i), {31'd0, uncorr_a}, {31'd0, vecs[i].unc});
            check($sformatf("v%0d syn_s1", i), {28'd0, syn_s1_a}, {28'd0, vecs[i].s1});
            check($sformatf("v%0d syn_s3", i), {28'd0, syn_s3_a}, {28'd0, vecs[i].s3});
            check($sformatf("v%0d out_cw_b", i), {17'd0, out_cw_b}, {17'd0, vecs[i].exp_cw});
            check($sformatf("v%0d err_count_b", i), {30'd0, err_count_b}, {30'd0, vecs[i].ec});
            check($sformatf("v%0d uncorr_b", i), {31'd0, uncorr_b}, {31'd0, vecs[i].unc});
            release_out();
        end

        // in_valid stays high throughout; output stalled for 10 cycles
        send(15'h01D9, 1'b1);
        wait_out(la, lb);
        check("bp lat", la, 31);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", {31'd0, out_valid_a}, 32'd1);
            check("bp in_ready", {31'd0, in_ready_a}, 32'd0);
            check("bp out_cw", {17'd0, out_cw_a}, 32'h01D1);
            check("bp err_count", {30'd0, err_count_a}, 32'd1);
        end
        release_out();
        in_valid = 1'b0;

        // reset on the edge of Chien step 7
        send(15'h01D9, 1'b0);
        repeat (23) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid rst in_ready", {31'd0, in_ready_a}, 32'd1);
        check("mid rst out_valid", {31'd0, out_valid_a}, 32'd0);
        check("mid rst out_cw", {17'd0, out_cw_a}, 32'd0);
        check("mid rst status", {21'd0, err_count_a, uncorr_a, syn_s1_a, syn_s3_a}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_a || out_valid_b) seen = 1'b1;
        end
        check("mid rst no output", {31'd0, seen}, 32'd0);

        send(15'h01D9, 1'b0);
        wait_out(la, lb);
        check("post rst lat", la, 31);
        check("post rst out_cw", {17'd0, out_cw_a}, 32'h01D1);
        check("post rst err_count", {30'd0, err_count_a}, 32'd1);
        check("post rst uncorr", {31'd0, uncorr_a}, 32'd0);
        check("post rst syn_s1", {28'd0, syn_s1_a}, 32'h8);
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
